// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: records every architectural register write of the
// single-cycle MIPS CPU as {seq, pc, addr, data} and drains them over a
// valid/ready stream. Overflows never stall the CPU. They are counted
// instead, and the sequence number still advances so the consumer sees a gap.
module wb_trace_fifo #(
    parameter int DEPTH   = 8,
    parameter int SEQ_W   = 16,
    parameter int DROP_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wb_en,
    input  logic [31:0]                wb_pc,
    input  logic [4:0]                 wb_addr,
    input  logic [31:0]                wb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [31:0]                out_pc,
    output logic [4:0]                 out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Record storage, one array per field; deliberately not reset
    logic [SEQ_W-1:0] mem_seq  [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [4:0]       mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [SEQ_W-1:0] seq_q;
    logic             overflow_q;
    logic [15:0]      drop_q;

    logic is_event;
    logic is_full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Classify this cycle: event filter, pop handshake, push or drop decision
    always_comb begin
        is_event = wb_en && !((DROP_R0 != 0) && (wb_addr == 5'd0));
        is_full  = (count_q == FULL_CNT);
        do_pop   = (count_q != '0) && out_ready;
        do_push  = is_event && (!is_full || do_pop);
        do_drop  = is_event && is_full && !do_pop;
    end

    // Pointers, occupancy, sequence counter and overflow bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (is_event) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (do_drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    // Write the accepted record into storage at the write pointer
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_seq[wr_ptr]  <= seq_q;
            mem_pc[wr_ptr]   <= wb_pc;
            mem_addr[wr_ptr] <= wb_addr;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    // Head record comes straight from storage; forced to zero while empty
    always_comb begin
        out_valid = (count_q != '0);
        out_seq   = '0;
        out_pc    = '0;
        out_addr  = '0;
        out_data  = '0;
        if (out_valid) begin
            out_seq  = mem_seq[rd_ptr];
            out_pc   = mem_pc[rd_ptr];
            out_addr = mem_addr[rd_ptr];
            out_data = mem_data[rd_ptr];
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule
